fetch_queue: RTL and testbench

//  Fetch stage directly downstream of the PC register. Takes the current PC,

---
 rtl/if_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 92 +++++++++
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package if_pkg;

    localparam int unsigned IF_XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_KILL = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [31:0]        instr;
    } fetch_entry_t;

    // Sequential PC of an instruction; wraps modulo 2^IF_XLEN.
    function automatic logic [IF_XLEN-1:0] pc_plus4(input logic [IF_XLEN-1:0] pc);
        return pc + IF_XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with push, pop and a
// flush that takes priority over both. DEPTH must be a power of two
// so the pointers wrap without extra compare logic.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    fetch_entry_t  mem_q [DEPTH];

    logic push_ok_s;
    logic pop_ok_s;

    assign empty_o   = (count_q == (AW+1)'(0));
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok_s  = pop_i && !empty_o;
    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer/occupancy: flush wins, otherwise push and pop update independently.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues one instruction-memory request at a time for the
// current PC, buffers returned {pc, instr} pairs for decode, and drops
// everything in flight when a branch redirect arrives.
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned XLEN  = IF_XLEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [XLEN-1:0]         pc_f,
    output logic                    pc_en,
    input  logic                    redirect,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [31:0]             imem_rdata,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [31:0]             dec_instr,
    output logic [XLEN-1:0]         dec_pc,
    output logic [XLEN-1:0]         dec_pcplus4,
    output logic [$clog2(DEPTH):0]  count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic         imem_req_s;
    logic         push_s;
    logic         pop_s;
    logic         fifo_empty_s;
    logic         fifo_full_s;
    fetch_entry_t push_entry_s;
    fetch_entry_t head_s;

    // Request only from S_REQ with room in the FIFO; a redirect withdraws it.
    assign imem_req_s = (state_q == S_REQ) && !redirect && !fifo_full_s;

    // Returned word is kept unless a redirect makes it wrong-path.
    assign push_s = (state_q == S_WAIT) && imem_rvalid && !redirect;
    assign pop_s  = !fifo_empty_s && dec_ready;

    assign push_entry_s.pc    = req_pc_q;
    assign push_entry_s.instr = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .flush_i     (redirect),
        .head_o      (head_s),
        .count_o     (count),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

    // FSM next state and request-PC capture on an accepted request.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_s && imem_gnt) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_f;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else if (redirect) begin
                    state_d = S_KILL;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_KILL: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_KILL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and outstanding-request PC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    // The PC advances when a request is accepted; a redirect loads the target.
    // Gated by reset_n so the PC register sees no enable while in reset.
    assign pc_en     = reset_n && ((imem_req_s && imem_gnt) || redirect);
    assign imem_req  = imem_req_s;
    assign imem_addr = imem_req_s ? pc_f : '0;

    assign dec_valid   = !fifo_empty_s;
    assign dec_instr   = head_s.instr;
    assign dec_pc      = head_s.pc;
    // Forced to zero in reset; the head entry itself is already cleared.
    assign dec_pcplus4 = reset_n ? pc_plus4(head_s.pc) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for streaming fetch and
// full-FIFO back-pressure, then hand sequences for stalls, redirects and reset.
module tb_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_f;
    logic        pc_en;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus4;
    logic [2:0]  count;

    int checks;
    int errors;

    localparam logic [31:0] I0 = 32'h1111_0000;
    localparam logic [31:0] I1 = 32'h2222_0001;
    localparam logic [31:0] I2 = 32'h3333_0002;
    localparam logic [31:0] I3 = 32'h4444_0003;
    localparam logic [31:0] I4 = 32'h5555_0004;
    localparam logic [31:0] I5 = 32'h6666_0005;
    localparam logic [31:0] PCW = 32'hFFFF_FFFC;
    localparam logic [31:0] IW  = 32'h0BAD_F00D;

    typedef struct packed {
        logic        rst;
        logic [31:0] pc;
        logic        redir;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic        e_pcen;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [2:0]  e_cnt;
        logic        chk_head;
    } vec_t;

    vec_t tv [19];

    fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_f        (pc_f),
        .pc_en       (pc_en),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_pcplus4 (dec_pcplus4),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build one vector; head fields are checked while reset or valid,
    // and the expected pc+4 is zero in reset, otherwise wraps at 32 bits.
    function automatic vec_t V(input logic rst, input logic [31:0] pc, input logic redir,
                               input logic gnt, input logic rv, input logic [31:0] rdata,
                               input logic rdy, input logic e_req, input logic e_pcen,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [2:0] e_cnt);
        vec_t v;
        v.rst      = rst;
        v.pc       = pc;
        v.redir    = redir;
        v.gnt      = gnt;
        v.rv       = rv;
        v.rdata    = rdata;
        v.rdy      = rdy;
        v.e_req    = e_req;
        v.e_pcen   = e_pcen;
        v.e_addr   = e_addr;
        v.e_valid  = e_valid;
        v.e_pc     = e_pc;
        v.e_instr  = e_instr;
        v.e_pc4    = rst ? (e_pc + 32'd4) : 32'd0;
        v.e_cnt    = e_cnt;
        v.chk_head = !rst || e_valid;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check outputs 1ns later.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        reset_n     = v.rst;
        pc_f        = v.pc;
        redirect    = v.redir;
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rdata;
        dec_ready   = v.rdy;
        #1;
        chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, v.e_req});
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, v.e_pcen});
        chk({tag, ".dec_valid"}, {31'd0, dec_valid}, {31'd0, v.e_valid});
        chk({tag, ".count"}, {29'd0, count}, {29'd0, v.e_cnt});
        if (v.e_req) begin
            chk({tag, ".imem_addr"}, imem_addr, v.e_addr);
        end
        if (v.chk_head) begin
            chk({tag, ".dec_pc"}, dec_pc, v.e_pc);
            chk({tag, ".dec_instr"}, dec_instr, v.e_instr);
            chk({tag, ".dec_pcplus4"}, dec_pcplus4, v.e_pc4);
        end
    endtask

    // Reset cycle followed by the single S_IDLE cycle.
    task automatic reset_idle(input string tag, input logic [31:0] pc);
        run_vec(V(1'b0, pc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0), {tag, ".rst"});
        run_vec(V(1'b1, pc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0), {tag, ".idle"});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        pc_f        = 32'd0;
        redirect    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        dec_ready   = 1'b0;

        // Streaming fetch with gnt/rvalid always high, then back-pressure to full.
        //        rst  pc      rd   gnt  rv   rdata rdy  req  pcen addr   val  hpc    hinstr cnt
        tv[0]  = V(1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'd0, 3'd0);
        tv[1]  = V(1'b1, 32'h00, 1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'd0, 3'd0);
        tv[2]  = V(1'b1, 32'h00, 1'b0, 1'b1, 1'b1, I0,    1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'd0, 3'd0);
        tv[3]  = V(1'b1, 32'h04, 1'b0, 1'b1, 1'b1, I0,    1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'd0, 3'd0);
        tv[4]  = V(1'b1, 32'h04, 1'b0, 1'b1, 1'b1, I1,    1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00, I0,    3'd1);
        tv[5]  = V(1'b1, 32'h08, 1'b0, 1'b1, 1'b1, I1,    1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, I0,    3'd1);
        tv[6]  = V(1'b1, 32'h08, 1'b0, 1'b1, 1'b1, I2,    1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, I0,    3'd2);
        tv[7]  = V(1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, I2,    1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, I0,    3'd2);
        tv[8]  = V(1'b1, 32'h0C, 1'b0, 1'b1, 1'b1, I3,    1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h00, I0,    3'd3);
        tv[9]  = V(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, I3,    1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, I0,    3'd3);
        tv[10] = V(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, I4,    1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, I0,    3'd4);
        tv[11] = V(1'b1, 32'h10, 1'b0, 1'b1, 1'b1, I4,    1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04, I1,    3'd3);
        tv[12] = V(1'b1, 32'h14, 1'b0, 1'b1, 1'b1, I4,    1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04, I1,    3'd3);
        tv[13] = V(1'b1, 32'h14, 1'b0, 1'b1, 1'b1, I5,    1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04, I1,    3'd4);
        tv[14] = V(1'b1, 32'h14, 1'b0, 1'b1, 1'b1, I5,    1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08, I2,    3'd3);
        tv[15] = V(1'b1, 32'h18, 1'b0, 1'b1, 1'b1, I5,    1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, I3,    3'd2);
        tv[16] = V(1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h10, I4,    3'd2);
        tv[17] = V(1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h18, 1'b1, 32'h14, I5,    3'd1);
        tv[18] = V(1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h18, 1'b0, 32'h00, 32'd0, 3'd0);

        for (int i = 0; i < 19; i++) begin
            run_vec(tv[i], $sformatf("tv%0d", i));
        end

        // Grant held off three cycles: request and address stay put, PC frozen.
        // The fetched PC is the top word so the decode pc+4 wraps to zero.
        reset_idle("gnt", PCW);
        for (int k = 0; k < 3; k++) begin
            run_vec(V(1'b1, PCW, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, PCW, 1'b0, 32'd0, 32'd0, 3'd0), $sformatf("gnt.hold%0d", k));
        end
        run_vec(V(1'b1, PCW,   1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, PCW,   1'b0, 32'd0, 32'd0, 3'd0), "gnt.accept");
        run_vec(V(1'b1, 32'd0, 1'b0, 1'b0, 1'b1, IW,    1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 3'd0), "gnt.resp");
        run_vec(V(1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, PCW,   IW,    3'd1), "gnt.wrap");

        // Redirect while waiting; the late response is discarded.
        reset_idle("kill", 32'h20);
        run_vec(V(1'b1, 32'h20,  1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 1'b1, 32'h20,  1'b0, 32'd0,   32'd0,     3'd0), "kill.req");
        run_vec(V(1'b1, 32'h24,  1'b1, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 32'd0,   1'b0, 32'd0,   32'd0,     3'd0), "kill.redir");
        run_vec(V(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0,     3'd0), "kill.wait");
        run_vec(V(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0,     3'd0), "kill.drop");
        run_vec(V(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'd0,   32'd0,     3'd0), "kill.target");
        run_vec(V(1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'd0,   1'b0, 32'd0,   32'd0,     3'd0), "kill.resp");
        run_vec(V(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 32'h100, 32'h00000013, 3'd1), "kill.head");

        // Fill to three, then push+pop+redirect together: everything flushed.
        reset_idle("flush", 32'h0);
        for (int k = 0; k < 3; k++) begin
            run_vec(V(1'b1, 32'(k * 4), 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'(k * 4),
                      (k != 0), 32'd0, 32'hC000_0000, 3'(k)), $sformatf("flush.req%0d", k));
            run_vec(V(1'b1, 32'(k * 4 + 4), 1'b0, 1'b0, 1'b1, 32'hC000_0000 + 32'(k), 1'b0, 1'b0, 1'b0, 32'd0,
                      (k != 0), 32'd0, 32'hC000_0000, 3'(k)), $sformatf("flush.rsp%0d", k));
        end
        run_vec(V(1'b1, 32'h0C,  1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 1'b1, 32'h0C,  1'b1, 32'd0, 32'hC000_0000, 3'd3), "flush.req3");
        run_vec(V(1'b1, 32'h10,  1'b1, 1'b0, 1'b1, 32'hC000_0003, 1'b1, 1'b0, 1'b1, 32'd0,   1'b1, 32'd0, 32'hC000_0000, 3'd3), "flush.all");
        run_vec(V(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'd0, 32'd0,         3'd0), "flush.after");

        // Reset asserted while waiting; a response after release is ignored.
        reset_idle("mrst", 32'h40);
        run_vec(V(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'd0,        1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'd0, 32'd0, 3'd0), "mrst.req");
        run_vec(V(1'b0, 32'h44, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0, 32'd0, 3'd0), "mrst.assert");
        run_vec(V(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h00001234, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0, 32'd0, 3'd0), "mrst.idle_rv");
        run_vec(V(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h00001234, 1'b0, 1'b1, 1'b0, 32'h44, 1'b0, 32'd0, 32'd0, 3'd0), "mrst.req_rv");
        run_vec(V(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 32'h44, 1'b0, 32'd0, 32'd0, 3'd0), "mrst.empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
